// File: rtl/prbs9_bert.sv
// PRBS9 (x^9+x^5+1) transmitter plus self-synchronising bit-error-rate checker.
// Ports: clock, i_reset (sync, active-high), i_enable (bit tick), i_rx_bit,
//        o_tx_bit, o_locked, o_err_count, o_bit_count (saturating counters).
module prbs9_bert #(
    parameter logic [8:0] SEED       = 9'h1AA,
    parameter int         NB_CNT     = 32,
    parameter int         LOS_ERRORS = 3
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_rx_bit,
    output logic              o_tx_bit,
    output logic              o_locked,
    output logic [NB_CNT-1:0] o_err_count,
    output logic [NB_CNT-1:0] o_bit_count
);

    localparam int NB_RUN = $clog2(LOS_ERRORS + 1);
    localparam logic [NB_RUN-1:0] RUN_LAST = NB_RUN'(LOS_ERRORS - 1);
    localparam logic [NB_CNT-1:0] CNT_MAX  = '1;

    typedef enum logic {
        SEARCH,
        CHECK
    } state_t;

    state_t              state_q, state_d;
    logic [8:0]          tx_lfsr_q;
    logic [8:0]          chk_q, chk_d;
    logic [3:0]          load_cnt_q, load_cnt_d;
    logic [NB_RUN-1:0]   err_run_q, err_run_d;
    logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;
    logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;
    logic                exp_bit;
    logic                rx_err;

    // Next-state and counter logic; every register holds when no tick.
    always_comb begin
        state_d    = state_q;
        chk_d      = chk_q;
        load_cnt_d = load_cnt_q;
        err_run_d  = err_run_q;
        err_cnt_d  = err_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        exp_bit    = chk_q[8] ^ chk_q[4];
        rx_err     = i_rx_bit ^ exp_bit;

        if (i_enable) begin
            case (state_q)
                SEARCH: begin
                    chk_d      = {chk_q[7:0], i_rx_bit};
                    load_cnt_d = load_cnt_q + 4'd1;
                    // Ninth bit loaded: lock unless the window is all-zero,
                    // which would only ever predict zeros.
                    if (load_cnt_q == 4'd8) begin
                        if (chk_d != 9'd0) begin
                            state_d = CHECK;
                        end else begin
                            load_cnt_d = 4'd0;
                        end
                    end
                end
                CHECK: begin
                    // Shift in the prediction so one bad bit cannot
                    // corrupt later predictions.
                    chk_d = {chk_q[7:0], exp_bit};
                    if (bit_cnt_q != CNT_MAX) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (rx_err) begin
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (err_run_q == RUN_LAST) begin
                            state_d    = SEARCH;
                            load_cnt_d = 4'd0;
                            err_run_d  = '0;
                        end else begin
                            err_run_d = err_run_q + NB_RUN'(1);
                        end
                    end else begin
                        err_run_d = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q    <= SEARCH;
            tx_lfsr_q  <= SEED;
            chk_q      <= 9'd0;
            load_cnt_q <= 4'd0;
            err_run_q  <= '0;
            err_cnt_q  <= '0;
            bit_cnt_q  <= '0;
        end else begin
            if (i_enable) begin
                tx_lfsr_q <= {tx_lfsr_q[7:0], tx_lfsr_q[8] ^ tx_lfsr_q[4]};
            end
            state_q    <= state_d;
            chk_q      <= chk_d;
            load_cnt_q <= load_cnt_d;
            err_run_q  <= err_run_d;
            err_cnt_q  <= err_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign o_tx_bit    = tx_lfsr_q[8];
    assign o_locked    = (state_q == CHECK);
    assign o_err_count = err_cnt_q;
    assign o_bit_count = bit_cnt_q;

endmodule

// File: tb/tb_prbs9_bert.sv
// Self-checking bench for prbs9_bert: sequence-level reference model plus
// directed loopback, error-injection, stuck-line and reset scenarios.
module tb_prbs9_bert;

    logic        clock = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_rx_bit;
    logic        o_tx_bit;
    logic        o_locked;
    logic [31:0] o_err_count;
    logic [31:0] o_bit_count;

    int n_checks = 0;
    int n_err    = 0;

    prbs9_bert dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_rx_bit    (i_rx_bit),
        .o_tx_bit    (o_tx_bit),
        .o_locked    (o_locked),
        .o_err_count (o_err_count),
        .o_bit_count (o_bit_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference PRBS9 stream: s[n] = s[n-9] ^ s[n-5], first nine bits = seed.
    bit s[511];
    initial begin
        logic [8:0] sd;
        sd = 9'h1AA;
        for (int i = 0; i < 9; i++) s[i] = sd[8-i];
        for (int i = 9; i < 511; i++) s[i] = s[i-9] ^ s[i-5];
    end

    // Behavioural model of the checker, in terms of the bit history.
    bit m_valid  = 0;
    int m_idx    = 0;
    bit m_locked = 0;
    int m_loaded = 0;
    int m_run    = 0;
    int m_errc   = 0;
    int m_bitc   = 0;
    bit m_exp;
    bit m_nz;
    bit hist[$];

    always @(posedge clock) begin
        if (i_reset) begin
            m_valid  = 1;
            m_idx    = 0;
            m_locked = 0;
            m_loaded = 0;
            m_run    = 0;
            m_errc   = 0;
            m_bitc   = 0;
            hist     = {};
            repeat (9) hist.push_back(1'b0);
        end else if (m_valid && i_enable) begin
            m_idx = (m_idx + 1) % 511;
            if (!m_locked) begin
                hist.push_back(i_rx_bit);
                void'(hist.pop_front());
                m_loaded++;
                if (m_loaded == 9) begin
                    m_nz = 0;
                    foreach (hist[j]) if (hist[j]) m_nz = 1;
                    if (m_nz) m_locked = 1;
                    else m_loaded = 0;
                end
            end else begin
                m_exp = hist[0] ^ hist[4];
                hist.push_back(m_exp);
                void'(hist.pop_front());
                m_bitc++;
                if (i_rx_bit !== m_exp) begin
                    m_errc++;
                    m_run++;
                    if (m_run == 3) begin
                        m_locked = 0;
                        m_loaded = 0;
                        m_run    = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("m_tx",     o_tx_bit,    s[m_idx]);
            check("m_locked", o_locked,    m_locked);
            check("m_errc",   o_err_count, m_errc);
            check("m_bitc",   o_bit_count, m_bitc);
        end
    end

    task automatic cyc(input logic en, input logic inv);
        i_enable = en;
        i_rx_bit = o_tx_bit ^ inv;
        @(negedge clock);
    endtask

    task automatic cyc_rx(input logic en, input logic rx);
        i_enable = en;
        i_rx_bit = rx;
        @(negedge clock);
    endtask

    initial begin
        logic [8:0] g;
        logic [6:0] pat;
        int k;
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_rx_bit = 1'b0;
        repeat (2) @(negedge clock);
        i_reset = 1'b0;
        check("rst_tx",     o_tx_bit,    1);
        check("rst_locked", o_locked,    0);
        check("rst_errc",   o_err_count, 0);
        check("rst_bitc",   o_bit_count, 0);

        // Loopback at full rate.
        g = '0;
        for (int i = 0; i < 1000; i++) begin
            if (i < 9) g[8-i] = o_tx_bit;
            cyc(1'b1, 1'b0);
            if (i == 7) check("lock_8th", o_locked, 0);
            if (i == 8) check("lock_9th", o_locked, 1);
        end
        check("seq_full", g, 9'h1AA);
        check("bitc_1000", o_bit_count, 991);
        check("errc_1000", o_err_count, 0);

        repeat (5) cyc(1'b0, 1'b0);
        check("hold_bitc", o_bit_count, 991);

        // Single inverted bit.
        cyc(1'b1, 1'b1);
        check("single_errc", o_err_count, 1);
        check("single_lock", o_locked, 1);
        repeat (50) cyc(1'b1, 1'b0);
        check("single_after_errc", o_err_count, 1);
        check("single_after_bitc", o_bit_count, 1042);

        // Three consecutive errors: lose lock, then re-lock.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check("los_2nd", o_locked, 1);
        cyc(1'b1, 1'b1);
        check("los_3rd", o_locked, 0);
        check("los_errc", o_err_count, 4);
        check("los_bitc", o_bit_count, 1045);
        repeat (8) cyc(1'b1, 1'b0);
        check("relock_8", o_locked, 0);
        cyc(1'b1, 1'b0);
        check("relock_9", o_locked, 1);
        check("relock_bitc", o_bit_count, 1045);
        repeat (20) cyc(1'b1, 1'b0);
        check("resume_bitc", o_bit_count, 1065);
        check("resume_errc", o_err_count, 4);

        // Reset together with enable while locked.
        i_reset = 1'b1;
        cyc(1'b1, 1'b0);
        i_reset = 1'b0;
        check("mid_rst_locked", o_locked, 0);
        check("mid_rst_errc", o_err_count, 0);
        check("mid_rst_bitc", o_bit_count, 0);
        check("mid_rst_tx", o_tx_bit, 1);

        // Stuck-at-0 receive line.
        repeat (50) cyc_rx(1'b1, 1'b0);
        check("stuck_locked", o_locked, 0);
        check("stuck_errc", o_err_count, 0);
        check("stuck_bitc", o_bit_count, 0);

        // Loopback with one tick in four.
        i_reset = 1'b1;
        cyc(1'b0, 1'b0);
        i_reset = 1'b0;
        g = '0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) begin
                if (k < 9) g[8-k] = o_tx_bit;
                k++;
                cyc(1'b1, 1'b0);
            end else begin
                cyc(1'b0, 1'b0);
            end
        end
        check("seq_div4", g, 9'h1AA);
        check("div4_locked", o_locked, 1);
        check("div4_bitc", o_bit_count, 1);

        // Scattered errors never reaching three in a row keep lock.
        repeat (20) cyc(1'b1, 1'b0);
        pat = 7'b1011011;
        for (int i = 6; i >= 0; i--) cyc(1'b1, pat[i]);
        check("scatter_locked", o_locked, 1);
        check("scatter_errc", o_err_count, 5);
        check("scatter_bitc", o_bit_count, 28);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
